// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - ID-stage branch hazard sequencer: stalls, forward selects, redirect/flush.
// Optional BRANCH_STATS_EN adds branch/taken/stall-cycle counters.
module branch_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int OPC_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic              branch_flag,
  output logic [1:0]        select1,
  output logic [1:0]        select2,
  output logic              stall,
  output logic              bubble_idex,
  output logic              pc_redirect,
  output logic              flush_ifid,
  output logic              busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_taken,
  output logic [31:0]       stat_stall_cycles
`endif
);

  localparam logic [OPC_W-1:0] OPC_BRANCH = OPC_W'(7'b1100011);

  typedef enum logic [1:0] {IDLE, STALL2, STALL1, RESOLVE} state_t;
  state_t state;

  logic       is_branch;
  logic [1:0] need1, need2, need;
  logic       stall_cyc, resolve_cyc;

  // Cycles a branch operand must wait for its producer; register 0 never matches.
  function automatic logic [1:0] op_need(input logic [REG_AW-1:0] rs);
    if (rs != '0 && ex_reg_write && ex_rd == rs)
      return ex_mem_read ? 2'd2 : 2'd1;
    else if (rs != '0 && mem_reg_write && mem_mem_read && mem_rd == rs)
      return 2'd1;
    else
      return 2'd0;
  endfunction

  function automatic logic [1:0] op_sel(input logic [REG_AW-1:0] rs);
    if (rs != '0 && mem_reg_write && !mem_mem_read && mem_rd == rs)
      return 2'b01;
    else if (rs != '0 && wb_reg_write && wb_rd == rs)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign is_branch = (id_opcode == OPC_BRANCH);
  assign need1     = op_need(id_rs1);
  assign need2     = op_need(id_rs2);
  assign need      = (need1 > need2) ? need1 : need2;

  assign stall_cyc   = (state == IDLE && is_branch && need != 2'd0) ||
                       state == STALL2 || state == STALL1;
  assign resolve_cyc = (state == IDLE && is_branch && need == 2'd0) ||
                       state == RESOLVE;

  // Reset forces every output low combinationally, not just at the next edge.
  always_comb begin
    select1     = 2'b00;
    select2     = 2'b00;
    stall       = 1'b0;
    bubble_idex = 1'b0;
    pc_redirect = 1'b0;
    flush_ifid  = 1'b0;
    busy        = 1'b0;
    if (!rst) begin
      if (is_branch) begin
        select1 = op_sel(id_rs1);
        select2 = op_sel(id_rs2);
      end
      stall       = stall_cyc;
      bubble_idex = stall_cyc;
      pc_redirect = branch_flag && resolve_cyc;
      flush_ifid  = branch_flag && resolve_cyc;
      busy        = (state != IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (is_branch && need == 2'd2)
            state <= STALL2;
          else if (is_branch && need == 2'd1)
            state <= STALL1;
        end
        STALL2:  state <= STALL1;
        STALL1:  state <= RESOLVE;
        RESOLVE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches     <= '0;
      stat_taken        <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (resolve_cyc)
        stat_branches <= stat_branches + 32'd1;
      if (resolve_cyc && branch_flag)
        stat_taken <= stat_taken + 32'd1;
      if (stall_cyc)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb/tb_branch_hazard_ctrl.sv - self-checking bench for branch_hazard_ctrl (default build).
module tb_branch_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read, wb_reg_write, branch_flag;
  logic [1:0] select1, select2;
  logic       stall, bubble_idex, pc_redirect, flush_ifid, busy;
  logic [8:0] act;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] ALU = 7'b0110011;

  always #5 clk = ~clk;

  branch_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .branch_flag(branch_flag),
    .select1(select1), .select2(select2), .stall(stall), .bubble_idex(bubble_idex),
    .pc_redirect(pc_redirect), .flush_ifid(flush_ifid), .busy(busy)
  );

  // Packed as {select1, select2, stall, bubble, redirect, flush, busy}.
  assign act = {select1, select2, stall, bubble_idex, pc_redirect, flush_ifid, busy};

  typedef struct {
    logic [6:0] opc;
    logic [4:0] rs1, rs2, erd;
    logic       erw, emr;
    logic [4:0] mrd;
    logic       mrw, mmr;
    logic [4:0] wrd;
    logic       wrw, flag;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[8];
  int   q[$];   // future cycle kinds after the current one: 1 = stall, 2 = resolve

  task automatic chk(input string name, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    id_opcode = v.opc; id_rs1 = v.rs1; id_rs2 = v.rs2;
    ex_rd = v.erd; ex_reg_write = v.erw; ex_mem_read = v.emr;
    mem_rd = v.mrd; mem_reg_write = v.mrw; mem_mem_read = v.mmr;
    wb_rd = v.wrd; wb_reg_write = v.wrw; branch_flag = v.flag;
  endtask

  task automatic clear_in();
    vec_t z;
    z = '{opc: 7'd0, rs1: 5'd0, rs2: 5'd0, erd: 5'd0, erw: 1'b0, emr: 1'b0, mrd: 5'd0,
          mrw: 1'b0, mmr: 1'b0, wrd: 5'd0, wrw: 1'b0, flag: 1'b0, exp: 9'd0};
    load(z);
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    q.delete();
  endtask

  // Reference: stall cycles a register needs, from where its producer sits.
  function automatic int need_of(input logic [4:0] rs);
    if (rs == 0) return 0;
    if (ex_reg_write && ex_rd == rs) return ex_mem_read ? 2 : 1;
    if (mem_reg_write && mem_mem_read && mem_rd == rs) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] sel_of(input logic [4:0] rs);
    if (id_opcode != BR || rs == 0) return 2'b00;
    if (mem_reg_write && !mem_mem_read && mem_rd == rs) return 2'b01;
    if (wb_reg_write && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  // Computes this cycle's expected outputs and schedules what the coming edges owe.
  function automatic logic [8:0] model_step();
    int  n, kind;
    logic s, r, b;
    if (rst) begin
      q.delete();
      return 9'd0;
    end
    s = 1'b0; r = 1'b0; b = (q.size() != 0);
    if (q.size() != 0) begin
      kind = q.pop_front();
      s = (kind == 1);
      r = (kind == 2);
    end else if (id_opcode == BR) begin
      n = need_of(id_rs1) > need_of(id_rs2) ? need_of(id_rs1) : need_of(id_rs2);
      if (n == 0) r = 1'b1;
      else begin
        s = 1'b1;
        for (int k = 0; k < n; k++) q.push_back(1);
        q.push_back(2);
      end
    end
    return {sel_of(id_rs1), sel_of(id_rs2), s, s, r & branch_flag, r & branch_flag, b};
  endfunction

  initial begin
    //          opc  rs1 rs2 erd erw emr mrd mrw mmr wrd wrw flg  expected
    tbl[0] = '{BR,  1,  2,  3,  1,  0,  4,  1,  0,  6,  1,  1, 9'b000000110};
    tbl[1] = '{BR,  1,  2,  3,  1,  0,  4,  1,  0,  6,  1,  0, 9'b000000000};
    tbl[2] = '{BR,  0,  2,  0,  1,  1,  0,  0,  0,  0,  0,  1, 9'b000000110};
    tbl[3] = '{BR,  1,  2,  3,  1,  0,  1,  1,  0,  2,  1,  0, 9'b011000000};
    tbl[4] = '{ALU, 1,  2,  1,  1,  1,  2,  1,  0,  2,  1,  1, 9'b000000000};
    tbl[5] = '{BR,  1,  2,  3,  1,  0,  1,  1,  1,  1,  1,  1, 9'b100011000};
    tbl[6] = '{BR,  1,  7,  7,  1,  1,  0,  0,  0,  0,  0,  1, 9'b000011000};
    tbl[7] = '{BR,  1,  2,  1,  0,  0,  1,  0,  0,  2,  0,  1, 9'b000000110};

    rst = 1'b1;
    clear_in();
    id_opcode = BR; id_rs1 = 5'd3; ex_rd = 5'd3; ex_reg_write = 1'b1; branch_flag = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("reset_state", 9'd0);
    clear_in();

    for (int i = 0; i < 8; i++) begin
      pulse_rst();
      load(tbl[i]);
      #1 chk($sformatf("table_%0d", i), tbl[i].exp);
    end

    // ALU producer in EX on rs1.
    pulse_rst(); clear_in();
    id_opcode = BR; id_rs1 = 5'd5; ex_rd = 5'd5; ex_reg_write = 1'b1;
    #1 chk("alu_idle", 9'b000011000);
    @(negedge clk); #1 chk("alu_stall1", 9'b000011001);
    @(negedge clk); ex_reg_write = 1'b0; mem_rd = 5'd5; mem_reg_write = 1'b1; branch_flag = 1'b1;
    #1 chk("alu_resolve", 9'b010000111);
    @(negedge clk); id_opcode = ALU;
    #1 chk("alu_after", 9'b000000000);

    // Load producer in EX on rs2.
    pulse_rst(); clear_in();
    id_opcode = BR; id_rs2 = 5'd7; ex_rd = 5'd7; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    #1 chk("load_idle", 9'b000011000);
    @(negedge clk); #1 chk("load_stall2", 9'b000011001);
    @(negedge clk); #1 chk("load_stall1", 9'b000011001);
    @(negedge clk); ex_reg_write = 1'b0; ex_mem_read = 1'b0; wb_rd = 5'd7; wb_reg_write = 1'b1;
    branch_flag = 1'b1;
    #1 chk("load_resolve", 9'b001000111);
    @(negedge clk); id_opcode = ALU;
    #1 chk("load_after", 9'b000000000);

    // Mixed hazards with branch_flag high throughout the stall.
    pulse_rst(); clear_in();
    id_opcode = BR; id_rs1 = 5'd3; mem_rd = 5'd3; mem_reg_write = 1'b1; mem_mem_read = 1'b1;
    id_rs2 = 5'd4; ex_rd = 5'd4; ex_reg_write = 1'b1; ex_mem_read = 1'b1; branch_flag = 1'b1;
    #1 chk("mix_idle", 9'b000011000);
    @(negedge clk); #1 chk("mix_stall2", 9'b000011001);
    @(negedge clk); #1 chk("mix_stall1", 9'b000011001);
    @(negedge clk); branch_flag = 1'b0;
    #1 chk("mix_resolve_nt", 9'b000000001);
    @(negedge clk); id_opcode = ALU;
    #1 chk("mix_after", 9'b000000000);

    // Reset asserted mid-stall.
    pulse_rst(); clear_in();
    id_opcode = BR; id_rs2 = 5'd7; ex_rd = 5'd7; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    branch_flag = 1'b1;
    @(negedge clk); #1 chk("rst_pre", 9'b000011001);
    #2 rst = 1'b1;
    #1 chk("rst_mid_stall", 9'b000000000);
    @(negedge clk); rst = 1'b0; id_opcode = ALU;
    #1 chk("rst_release", 9'b000000000);
    @(negedge clk); #1 chk("rst_idle", 9'b000000000);

    // Randomized traffic against the reference model.
    pulse_rst(); q.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst           = ($urandom_range(0, 49) == 0);
      id_opcode     = ($urandom_range(0, 9) < 7) ? BR : ALU;
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      ex_rd         = 5'($urandom_range(0, 3));
      ex_reg_write  = 1'($urandom_range(0, 1));
      ex_mem_read   = ex_reg_write & 1'($urandom_range(0, 1));
      mem_rd        = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      mem_mem_read  = mem_reg_write & 1'($urandom_range(0, 1));
      wb_rd         = 5'($urandom_range(0, 3));
      wb_reg_write  = 1'($urandom_range(0, 1));
      branch_flag   = 1'($urandom_range(0, 1));
      #1 chk($sformatf("random_%0d", c), model_step());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
